// File: rtl/lifo_pkg.sv
// +-----------------------------------------------------------------------+
// | lifo_pkg : shared defaults, counter width and FSM encodings for the   |
// | LIFO sequencer.                              rev 1.0                  |
// +-----------------------------------------------------------------------+
`default_nettype none

package lifo_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 12;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   typedef enum logic {
      OP_POP  = 1'b0,
      OP_PUSH = 1'b1
   } op_t;

endpackage

`default_nettype wire

// File: rtl/lifo_occ_counter.sv
// +-----------------------------------------------------------------------+
// | lifo_occ_counter : saturating up/down occupancy counter with          |
// | full/empty flags.                            rev 1.0                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module lifo_occ_counter
   import lifo_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && count != C_MAX) begin
         count <= count + CNT_W'(1);
      end else if (dec && !inc && count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign full  = (count == C_MAX);
   assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/lifo_sequencer.sv
// +-----------------------------------------------------------------------+
// | lifo_sequencer : four-phase push/pop sequencer for an external        |
// | level-sensitive LIFO on a shared tristate bus.   rev 1.0              |
// +-----------------------------------------------------------------------+
`default_nettype none

module lifo_sequencer
   import lifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       pop_req,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       lifo_rst,
   output logic                       lifo_en,
   output logic                       lifo_push_pop,
   inout  wire  [WIDTH-1:0]           lifo_data
);

   state_t           state;
   state_t           state_nx;
   op_t              op;
   logic [WIDTH-1:0] hold_word;
   logic             drive_en;
   logic             rst_d;
   logic             pick_pop;
   logic             pick_push;
   logic             occ_inc;
   logic             occ_dec;

   // Stretch the LIFO reset one cycle past rst so it clears alongside count.
   always_ff @(posedge clk) begin
      rst_d <= rst;
   end
   assign lifo_rst = rst | rst_d;

   always_comb begin
      state_nx  = state;
      pick_pop  = 1'b0;
      pick_push = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!lifo_rst) begin
               if (pop_req && !empty && !out_valid) begin
                  pick_pop = 1'b1;
                  state_nx = ST_SETUP;
               end else if (in_valid && !full) begin
                  pick_push = 1'b1;
                  state_nx  = ST_SETUP;
               end
            end
         end
         ST_SETUP:  state_nx = ST_STROBE;
         ST_STROBE: state_nx = ST_HOLD;
         ST_HOLD:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   assign in_ready = pick_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op        <= OP_PUSH;
         hold_word <= '0;
         drive_en  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_nx;
         if (pick_pop) begin
            op <= OP_POP;
         end
         if (pick_push) begin
            op        <= OP_PUSH;
            hold_word <= in_data;
         end
         // Bus is owned from SETUP through HOLD of a push only.
         drive_en <= pick_push | (drive_en && state != ST_HOLD);
         if (state == ST_STROBE && op == OP_POP) begin
            out_data  <= lifo_data;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign lifo_en       = (state == ST_STROBE);
   assign lifo_push_pop = (state == ST_IDLE) | (op == OP_PUSH);
   assign lifo_data     = drive_en ? hold_word : {WIDTH{1'bz}};

   assign occ_inc = (state == ST_STROBE) && (op == OP_PUSH);
   assign occ_dec = (state == ST_STROBE) && (op == OP_POP);

   lifo_occ_counter #(
      .DEPTH (DEPTH)
   ) u_occ (
      .clk   (clk),
      .rst   (rst),
      .inc   (occ_inc),
      .dec   (occ_dec),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule

`default_nettype wire

// File: tb/tb_lifo_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_lifo_sequencer : scoreboard bench with a behavioural LIFO on the   |
// | shared bus.                                  rev 1.0                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_lifo_sequencer;

   localparam int W  = 8;
   localparam int D  = 12;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          pop_req = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          lifo_rst;
   logic          lifo_en;
   logic          lifo_push_pop;
   wire  [W-1:0]  lifo_data;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [W-1:0] shadow[$];
   logic [W-1:0] exp_q[$];

   logic [3:0]   en_hist;
   logic [3:0]   pp_hist;
   logic [W-1:0] bus_hist [4];

   always #5 clk = ~clk;

   lifo_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .pop_req       (pop_req),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .lifo_rst      (lifo_rst),
      .lifo_en       (lifo_en),
      .lifo_push_pop (lifo_push_pop),
      .lifo_data     (lifo_data)
   );

   // Attached level-sensitive LIFO: drives the bus only while a pop is strobed.
   logic [W-1:0] lmem [16];
   logic [4:0]   lsp;
   logic [3:0]   ltop;
   assign ltop      = 4'(lsp - 5'd1);
   assign lifo_data = (lifo_en && !lifo_push_pop) ? lmem[ltop] : {W{1'bz}};

   always @(posedge clk) begin
      if (lifo_rst) begin
         lsp <= '0;
      end else if (lifo_en) begin
         if (lifo_push_pop) begin
            lmem[lsp[3:0]] <= lifo_data;
            lsp            <= lsp + 5'd1;
         end else begin
            lsp <= lsp - 5'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Consumer side of the scoreboard.
   always begin
      @(negedge clk);
      #3;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("sb_unexpected_pop", 32'd1, 32'd0);
         else                   check("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      pop_req  = 1'b0;
      shadow.delete();
      exp_q.delete();
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic push_word(input logic [W-1:0] v);
      bit got = 0;
      in_valid = 1'b1;
      in_data  = v;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            got = 1;
            break;
         end
         tick(1);
      end
      if (!got) begin
         check("push_timeout", 32'd1, 32'd0);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      shadow.push_back(v);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) in_valid = 1'b0;
         #1;
         en_hist[k]  = lifo_en;
         pp_hist[k]  = lifo_push_pop;
         bus_hist[k] = lifo_data;
      end
   endtask

   task automatic pop_word();
      bit got = 0;
      if (shadow.size() > 0) exp_q.push_back(shadow.pop_back());
      pop_req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (out_valid) begin
            got = 1;
            break;
         end
      end
      pop_req = 1'b0;
      if (!got) check("pop_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lr_hi;
      bit stable;

      // Reset state, with in_valid held to prove nothing is accepted.
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick(3);
      check("rst_count",     {28'd0, count}, 32'd0);
      check("rst_empty",     {31'd0, empty}, 32'd1);
      check("rst_full",      {31'd0, full}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {24'd0, out_data}, 32'd0);
      check("rst_lifo_rst",  {31'd0, lifo_rst}, 32'd1);
      check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      check("rst_lifo_en",   {31'd0, lifo_en}, 32'd0);
      in_valid = 1'b0;
      reset_dut();

      // Single push: strobe timing and bus drive.
      push_word(8'hA5);
      check("push_en_pattern", {28'd0, en_hist}, 32'h2);
      check("push_pp_pattern", {28'd0, pp_hist}, 32'hF);
      check("push_bus_setup",  {24'd0, bus_hist[0]}, 32'hA5);
      check("push_bus_strobe", {24'd0, bus_hist[1]}, 32'hA5);
      check("push_bus_hold",   {24'd0, bus_hist[2]}, 32'hA5);
      check("push_count1",     {28'd0, count}, 32'd1);
      pop_word();
      tick(1);

      // LIFO order.
      reset_dut();
      push_word(8'h01);
      push_word(8'h02);
      push_word(8'h03);
      check("order_count3", {28'd0, count}, 32'd3);
      pop_word();
      check("pop_count_dec", {28'd0, count}, 32'd2);
      tick(1);
      pop_word();
      tick(1);
      pop_word();
      tick(1);
      check("order_count0", {28'd0, count}, 32'd0);
      check("order_empty",  {31'd0, empty}, 32'd1);

      // Fill to capacity, hold off pushes, pop once.
      reset_dut();
      for (int i = 0; i < D; i++) push_word(8'(8'h10 + i));
      check("fill_full",  {31'd0, full}, 32'd1);
      check("fill_count", {28'd0, count}, 32'd12);
      in_valid = 1'b1;
      in_data  = 8'h5C;
      tick(5);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_count_sat", {28'd0, count}, 32'd12);
      pop_word();
      tick(1);
      check("unfull_count",    {28'd0, count}, 32'd11);
      check("unfull_in_ready", {31'd0, in_ready}, 32'd1);
      push_word(8'h5C);
      check("refill_count", {28'd0, count}, 32'd12);

      // Pop wins arbitration over a simultaneous push.
      reset_dut();
      for (int i = 0; i < 5; i++) push_word(8'(8'h40 + i));
      exp_q.push_back(shadow.pop_back());
      pop_req  = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      #1;
      check("arb_pop_first", {31'd0, in_ready}, 32'd0);
      stable = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (out_valid) begin
            stable = 1;
            break;
         end
      end
      pop_req = 1'b0;
      check("arb_pop_done", {31'd0, stable}, 32'd1);
      check("arb_count4",   {28'd0, count}, 32'd4);
      push_word(8'h77);
      check("arb_count5",   {28'd0, count}, 32'd5);
      for (int i = 0; i < 5; i++) begin
         pop_word();
         tick(1);
      end
      check("arb_drained", {31'd0, empty}, 32'd1);

      // Reset in the middle of a push strobe.
      reset_dut();
      in_valid = 1'b1;
      in_data  = 8'h3C;
      #1;
      for (int i = 0; i < 50 && !in_ready; i++) tick(1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      tick(1);
      check("mid_strobe_en", {31'd0, lifo_en}, 32'd1);
      rst = 1'b1;
      #1;
      lr_hi = lifo_rst ? 1 : 0;
      tick(1);
      check("mid_rst_en",    {31'd0, lifo_en}, 32'd0);
      check("mid_rst_count", {28'd0, count}, 32'd0);
      check("mid_rst_pp",    {31'd0, lifo_push_pop}, 32'd1);
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h99;
      #1;
      lr_hi += lifo_rst ? 1 : 0;
      check("lifo_rst_block", {31'd0, in_ready}, 32'd0);
      tick(1);
      lr_hi += lifo_rst ? 1 : 0;
      check("lifo_rst_cycles", lr_hi, 32'd2);
      check("lifo_rst_no_op",  {28'd0, count}, 32'd0);
      in_valid = 1'b0;
      shadow.delete();
      push_word(8'h99);
      pop_word();
      tick(1);
      check("post_rst_empty", {31'd0, empty}, 32'd1);

      // Back-pressured output: data holds, pops blocked, pushes proceed.
      reset_dut();
      push_word(8'h21);
      push_word(8'h22);
      push_word(8'h23);
      out_ready = 1'b0;
      pop_word();
      pop_req = 1'b1;
      stable  = 1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (out_data !== 8'h23 || !out_valid) stable = 0;
      end
      pop_req = 1'b0;
      check("bp_data_stable", {31'd0, stable}, 32'd1);
      check("bp_pop_blocked", {28'd0, count}, 32'd2);
      push_word(8'h24);
      check("bp_push_ok", {28'd0, count}, 32'd3);
      out_ready = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         pop_word();
         tick(1);
      end
      check("bp_empty", {31'd0, empty}, 32'd1);

      tick(2);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

`default_nettype wire
